// File: rtl/packet_pad_restorer.sv
// Restores truncated packets to the length carried in tuser[15:0] by zero-padding
// the tail. Pass-through is combinational; padding beats are generated from a local state.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FIRST | waiting for the first beat of a packet (target/pad_en latched on it)
// S_PASS  | forwarding the body of a packet
// S_PAD   | input stalled, emitting zero beats until the target length is met
module packet_pad_restorer #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,

  input  logic                              pad_en,
  output logic [31:0]                       pad_pkt_cnt,
  output logic [31:0]                       pass_pkt_cnt
);

  localparam int C_BYTES = C_M_AXIS_DATA_WIDTH / 8;

  localparam logic [1:0] S_FIRST = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_PAD   = 2'd2;

  logic [1:0]                      r_state;
  logic [15:0]                     r_rx_bytes;
  logic [15:0]                     r_target;
  logic [15:0]                     r_remaining;
  logic                            r_pkt_pad;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] r_tuser;
  logic [31:0]                     r_pad_pkt_cnt;
  logic [31:0]                     r_pass_pkt_cnt;

  logic                            w_first;
  logic [16:0]                     w_pop;
  logic [16:0]                     w_cur_rx;
  logic [16:0]                     w_cur_target;
  logic                            w_cur_pad;
  logic [16:0]                     w_total;
  logic                            w_extend;
  logic [16:0]                     w_need;
  logic                            w_need_last;
  logic [16:0]                     w_rem;
  logic                            w_pad_last;
  logic                            w_in_fire;
  logic                            w_out_fire;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  w_masked_data;

  function automatic logic [C_BYTES-1:0] f_keep(input logic [16:0] n);
    logic [C_BYTES-1:0] v;
    v = '0;
    for (int i = 0; i < C_BYTES; i++) begin
      v[i] = (17'(i) < n);
    end
    return v;
  endfunction

  assign w_first = (r_state == S_FIRST);

  // tkeep is contiguous, so its popcount is the byte count of the beat
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < C_BYTES; i++) begin
      w_pop = w_pop + {16'd0, s_axis_tkeep[i]};
    end
  end

  always_comb begin
    w_masked_data = '0;
    for (int i = 0; i < C_BYTES; i++) begin
      w_masked_data[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'd0;
    end
  end

  // On the first beat the packet context comes straight from the input, not the latches
  assign w_cur_rx     = w_first ? 17'd0 : {1'b0, r_rx_bytes};
  assign w_cur_target = w_first ? {1'b0, s_axis_tuser[15:0]} : {1'b0, r_target};
  assign w_cur_pad    = w_first ? pad_en : r_pkt_pad;
  assign w_total      = w_cur_rx + w_pop;
  assign w_extend     = s_axis_tlast & w_cur_pad & (w_total < w_cur_target);
  assign w_need       = w_cur_target - w_cur_rx;
  assign w_need_last  = (w_need <= 17'(C_BYTES));

  assign w_rem        = {1'b0, r_remaining};
  assign w_pad_last   = (w_rem <= 17'(C_BYTES));

  assign w_in_fire    = s_axis_tvalid & s_axis_tready;
  assign w_out_fire   = m_axis_tvalid & m_axis_tready;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    if (!axi_reset) begin
      case (r_state)
        S_FIRST, S_PASS: begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          if (w_extend) begin
            m_axis_tdata = w_masked_data;
            m_axis_tkeep = f_keep(w_need);
            m_axis_tlast = w_need_last;
            m_axis_tuser = w_first ? s_axis_tuser : r_tuser;
          end else begin
            m_axis_tdata = s_axis_tdata;
            m_axis_tkeep = s_axis_tkeep;
            m_axis_tlast = s_axis_tlast;
            m_axis_tuser = s_axis_tuser;
          end
        end
        S_PAD: begin
          m_axis_tvalid = 1'b1;
          m_axis_tkeep  = f_keep(w_rem);
          m_axis_tlast  = w_pad_last;
          m_axis_tuser  = r_tuser;
        end
        default: begin
          m_axis_tvalid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state        <= S_FIRST;
      r_rx_bytes     <= '0;
      r_target       <= '0;
      r_remaining    <= '0;
      r_pkt_pad      <= 1'b0;
      r_tuser        <= '0;
      r_pad_pkt_cnt  <= '0;
      r_pass_pkt_cnt <= '0;
    end else begin
      case (r_state)
        S_FIRST, S_PASS: begin
          if (w_in_fire) begin
            if (w_first) begin
              r_target  <= s_axis_tuser[15:0];
              r_pkt_pad <= pad_en;
              r_tuser   <= s_axis_tuser;
            end
            if (!s_axis_tlast) begin
              r_state    <= S_PASS;
              r_rx_bytes <= w_total[15:0];
            end else if (w_extend && !w_need_last) begin
              r_state     <= S_PAD;
              r_rx_bytes  <= '0;
              r_remaining <= 16'(w_need - 17'(C_BYTES));
            end else begin
              r_state    <= S_FIRST;
              r_rx_bytes <= '0;
              if (w_extend) begin
                r_pad_pkt_cnt <= r_pad_pkt_cnt + 32'd1;
              end else begin
                r_pass_pkt_cnt <= r_pass_pkt_cnt + 32'd1;
              end
            end
          end
        end
        S_PAD: begin
          if (w_out_fire) begin
            if (w_pad_last) begin
              r_state       <= S_FIRST;
              r_remaining   <= '0;
              r_pad_pkt_cnt <= r_pad_pkt_cnt + 32'd1;
            end else begin
              r_remaining <= r_remaining - 16'(C_BYTES);
            end
          end
        end
        default: begin
          r_state <= S_FIRST;
        end
      endcase
    end
  end

  assign pad_pkt_cnt  = r_pad_pkt_cnt;
  assign pass_pkt_cnt = r_pass_pkt_cnt;

endmodule

// File: tb/tb_packet_pad_restorer.sv
// Randomized bench for packet_pad_restorer: each packet's expected output is built
// from the length-restoration rules as a byte-chunk list, then compared beat by beat.
module tb_packet_pad_restorer;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  logic         axi_aclk = 1'b0;
  logic         axi_reset;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         pad_en;
  logic [31:0]  pad_pkt_cnt;
  logic [31:0]  pass_pkt_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pad_cnt = 0;
  logic [31:0] m_pass_cnt = 0;

  packet_pad_restorer dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pad_en        (pad_en),
    .pad_pkt_cnt   (pad_pkt_cnt),
    .pass_pkt_cnt  (pass_pkt_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] keep_of(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) if (i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_counters();
    check("pad_pkt_cnt", pad_pkt_cnt, m_pad_cnt);
    check("pass_pkt_cnt", pass_pkt_cnt, m_pass_cnt);
  endtask

  // Sends one packet of nbytes bytes carrying target length in tuser[15:0]
  task automatic run_packet(input int nbytes, input int target, input bit pen, input bit stall);
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t b, e;
    int nb, rx_before, rem, bi, oi, cycles;
    bit hold, have_prev, ext, first_chunk;
    logic [289:0] prev;

    nb = (nbytes + 31) / 32;
    for (int i = 0; i < nb; i++) begin
      b.d = rand256();
      b.k = keep_of((i == nb - 1) ? nbytes - 32 * i : 32);
      b.l = (i == nb - 1);
      b.u = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0) b.u[15:0] = target[15:0];
      in_q.push_back(b);
    end

    rx_before = 32 * (nb - 1);
    ext = pen && (nbytes < target);
    if (!ext) begin
      foreach (in_q[i]) exp_q.push_back(in_q[i]);
      m_pass_cnt = m_pass_cnt + 1;
    end else begin
      for (int i = 0; i < nb - 1; i++) exp_q.push_back(in_q[i]);
      rem = target - rx_before;
      first_chunk = 1'b1;
      while (rem > 0) begin
        e.d = '0;
        if (first_chunk) begin
          for (int j = 0; j < 32; j++)
            if (in_q[nb-1].k[j]) e.d[8*j +: 8] = in_q[nb-1].d[8*j +: 8];
        end
        e.k = keep_of(rem > 32 ? 32 : rem);
        e.l = (rem <= 32);
        e.u = in_q[0].u;
        exp_q.push_back(e);
        rem = rem - 32;
        first_chunk = 1'b0;
      end
      m_pad_cnt = m_pad_cnt + 1;
    end

    bi = 0; oi = 0; cycles = 0; hold = 0; have_prev = 0; prev = '0;
    while (oi < exp_q.size() && cycles < 3000) begin
      @(negedge axi_aclk);
      if (!hold) begin
        if (bi < nb && (!stall || $urandom_range(3) != 0)) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = in_q[bi].d;
          s_axis_tkeep  = in_q[bi].k;
          s_axis_tlast  = in_q[bi].l;
          s_axis_tuser  = in_q[bi].u;
          pad_en        = (bi == 0) ? pen : 1'($urandom);
        end else begin
          s_axis_tvalid = 1'b0;
          s_axis_tdata  = rand256();
          s_axis_tlast  = 1'($urandom);
          pad_en        = 1'($urandom);
        end
      end
      m_axis_tready = stall ? ($urandom_range(2) != 0) : 1'b1;
      #1;
      if (have_prev)
        check("stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid}, prev);
      if (m_axis_tvalid && m_axis_tready) begin
        e = exp_q[oi];
        check("tdata", m_axis_tdata, e.d);
        check("tkeep", m_axis_tkeep, e.k);
        check("tlast", m_axis_tlast, e.l);
        check("tuser", m_axis_tuser, e.u);
        oi++;
      end
      have_prev = m_axis_tvalid && !m_axis_tready;
      prev = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid};
      if (s_axis_tvalid && s_axis_tready) begin
        bi++;
        hold = 1'b0;
      end else begin
        hold = s_axis_tvalid;
      end
      cycles++;
    end
    check("out_beats", oi, exp_q.size());
    check("in_beats", bi, nb);
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check_counters();
  endtask

  initial begin
    axi_reset     = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand256();
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    m_axis_tready = 1'b1;
    pad_en        = 1'b1;

    repeat (2) @(negedge axi_aclk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tlast", m_axis_tlast, 1'b0);
    check("rst_m_tkeep", m_axis_tkeep, 32'd0);
    check("rst_m_tdata", m_axis_tdata, 256'd0);
    check_counters();

    @(negedge axi_aclk);
    axi_reset     = 1'b0;
    s_axis_tvalid = 1'b0;

    run_packet(64, 100, 1'b1, 1'b0);
    run_packet(8, 40, 1'b1, 1'b0);
    run_packet(64, 200, 1'b0, 1'b0);
    run_packet(64, 64, 1'b1, 1'b0);
    run_packet(64, 100, 1'b1, 1'b1);
    run_packet(32, 0, 1'b1, 1'b0);
    run_packet(1, 33, 1'b1, 1'b1);
    run_packet(70, 65, 1'b1, 1'b0);

    // Reset while a packet is being padded
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand256();
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = {$urandom, $urandom, $urandom, 16'($urandom), 16'd200};
    pad_en        = 1'b1;
    m_axis_tready = 1'b1;
    #1;
    check("ext_beat_tlast", m_axis_tlast, 1'b0);
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    #1;
    check("pad_tvalid", m_axis_tvalid, 1'b1);
    check("pad_s_tready", s_axis_tready, 1'b0);
    check("pad_tdata", m_axis_tdata, 256'd0);
    @(negedge axi_aclk);
    axi_reset = 1'b1;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    @(negedge axi_aclk);
    axi_reset = 1'b0;
    #1;
    check("postrst_tvalid", m_axis_tvalid, 1'b0);
    check("postrst_s_tready", s_axis_tready, 1'b1);
    m_pad_cnt  = 0;
    m_pass_cnt = 0;
    check_counters();
    run_packet(32, 77, 1'b0, 1'b0);

    for (int p = 0; p < 40; p++) begin
      run_packet($urandom_range(160, 1), $urandom_range(220, 0),
                 1'($urandom), 1'($urandom));
    end

    // Counter wrap from all-ones
    @(negedge axi_aclk);
    force dut.r_pad_pkt_cnt = 32'hFFFF_FFFF;
    @(negedge axi_aclk);
    release dut.r_pad_pkt_cnt;
    #1;
    check("pad_cnt_preload", pad_pkt_cnt, 32'hFFFF_FFFF);
    m_pad_cnt = 32'hFFFF_FFFF;
    run_packet(10, 50, 1'b1, 1'b0);
    check("pad_cnt_wrap", pad_pkt_cnt, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
